// File: rtl/spi_reg_ctrl_if.sv
// SPI pins and register-bus signals of spi_reg_ctrl, bundled for port connection.
// The slave modport is the controller's view; the master modport is the SPI host / register file side.
interface spi_reg_ctrl_if #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8
);
   logic                 I_csb;
   logic                 I_sclk;
   logic                 I_sdi;
   logic                 O_sdo;
   logic                 O_sdo_oe;
   logic                 O_reg_enable;
   logic                 O_reg_wen;
   logic [ADDR_SIZE-1:0] O_reg_addr;
   logic [DATA_SIZE-1:0] O_reg_din;
   logic [DATA_SIZE-1:0] I_reg_dout;

   modport slave (
      input  I_csb, I_sclk, I_sdi, I_reg_dout,
      output O_sdo, O_sdo_oe, O_reg_enable, O_reg_wen, O_reg_addr, O_reg_din
   );

   modport master (
      output I_csb, I_sclk, I_sdi, I_reg_dout,
      input  O_sdo, O_sdo_oe, O_reg_enable, O_reg_wen, O_reg_addr, O_reg_din
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI slave to register-bus bridge: 16-bit instruction, then 1..4 data bytes with auto-increment.
// Define SPI_STREAM_EN to make W=11 stream bytes until CSB rises; otherwise W=11 means 4 bytes.
module spi_reg_ctrl #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8
) (
   input  logic          I_clk,
   input  logic          I_rst_n,
   spi_reg_ctrl_if.slave bus
);
   localparam int INSTR_BITS = 16;
   localparam int CNT_W      = $clog2(INSTR_BITS > DATA_SIZE ? INSTR_BITS : DATA_SIZE);
   localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_BITS - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      INSTR,
      WR_DATA,
      RD_DATA,
      WAIT_CSB
   } state_t;

   state_t state;

   logic csb_meta, csb_sync, csb_prev;
   logic sclk_meta, sclk_sync, sclk_prev;
   logic sdi_meta, sdi_sync;

   logic [INSTR_BITS-2:0] instr_sr;
   logic [DATA_SIZE-2:0]  data_sr;
   logic [DATA_SIZE-1:0]  tx_sr;
   logic [CNT_W-1:0]      bit_cnt;
   logic [1:0]            byte_cnt;
   logic [1:0]            w_field;
   logic [1:0]            rd_pipe;
   logic                  inc_pend;

   logic                  sdo;
   logic                  sdo_oe;
   logic                  reg_enable;
   logic                  reg_wen;
   logic [ADDR_SIZE-1:0]  reg_addr;
   logic [DATA_SIZE-1:0]  reg_din;

   logic                  csb_fall;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  byte_last;
   logic                  load_now;
   logic [INSTR_BITS-1:0] instr_word;
   logic [DATA_SIZE-1:0]  data_word;
   logic [DATA_SIZE-1:0]  tx_src;

   // NOTE: every flop in this file uses non-blocking assignments so that all
   // registers see pre-edge values; blocking here would collapse the synchronizer stages.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         csb_meta  <= 1'b0;
         csb_sync  <= 1'b0;
         csb_prev  <= 1'b0;
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         sdi_meta  <= 1'b0;
         sdi_sync  <= 1'b0;
      end else begin
         csb_meta  <= bus.I_csb;
         csb_sync  <= csb_meta;
         csb_prev  <= csb_sync;
         sclk_meta <= bus.I_sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         sdi_meta  <= bus.I_sdi;
         sdi_sync  <= sdi_meta;
      end
   end

   // Synchronizers clear to 0, so a CSB held low across reset release never looks like a fall.
   assign csb_fall  = csb_prev & ~csb_sync;
   assign sclk_rise = sclk_sync & ~sclk_prev;
   assign sclk_fall = ~sclk_sync & sclk_prev;

   assign instr_word = {instr_sr, sdi_sync};
   assign data_word  = {data_sr, sdi_sync};

   // A read byte load can coincide with the first falling edge at 4x SCLK; shift from the fresh data then.
   assign load_now = rd_pipe[1];
   assign tx_src   = load_now ? bus.I_reg_dout : tx_sr;

`ifdef SPI_STREAM_EN
   assign byte_last = (w_field != 2'b11) && (byte_cnt == w_field);
`else
   assign byte_last = (byte_cnt == w_field);
`endif

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state      <= IDLE;
         instr_sr   <= '0;
         data_sr    <= '0;
         tx_sr      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         w_field    <= '0;
         rd_pipe    <= '0;
         inc_pend   <= 1'b0;
         sdo        <= 1'b0;
         sdo_oe     <= 1'b0;
         reg_enable <= 1'b0;
         reg_wen    <= 1'b0;
         reg_addr   <= '0;
         reg_din    <= '0;
      end else begin
         reg_wen <= 1'b0;
         rd_pipe <= {rd_pipe[0], 1'b0};

         // Address bumps one cycle after a write strobe or a read load; natural wrap at 2^ADDR_SIZE.
         if (inc_pend) begin
            reg_addr <= reg_addr + 1'b1;
            inc_pend <= 1'b0;
         end

         // Abort needs csb_sync high, so a CSB fall can only be seen later from IDLE and is never dropped.
         if (state != IDLE && csb_sync) begin
            state      <= IDLE;
            reg_enable <= 1'b0;
            sdo_oe     <= 1'b0;
            sdo        <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            rd_pipe    <= '0;
            tx_sr      <= '0;
            data_sr    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (csb_fall) begin
                     state    <= INSTR;
                     bit_cnt  <= '0;
                     byte_cnt <= '0;
                  end
               end

               INSTR: begin
                  if (sclk_rise) begin
                     instr_sr <= instr_word[INSTR_BITS-2:0];
                     if (bit_cnt == INSTR_LAST) begin
                        bit_cnt    <= '0;
                        reg_addr   <= ADDR_SIZE'(instr_word[12:0]);
                        w_field    <= instr_word[14:13];
                        reg_enable <= 1'b1;
                        if (instr_word[15]) begin
                           state   <= RD_DATA;
                           sdo_oe  <= 1'b1;
                           rd_pipe <= {rd_pipe[0], 1'b1};
                        end else begin
                           state <= WR_DATA;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end

               WR_DATA: begin
                  if (sclk_rise) begin
                     data_sr <= data_word[DATA_SIZE-2:0];
                     if (bit_cnt == BYTE_LAST) begin
                        bit_cnt  <= '0;
                        reg_din  <= data_word;
                        reg_wen  <= 1'b1;
                        inc_pend <= 1'b1;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_last) state <= WAIT_CSB;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end

               RD_DATA: begin
                  if (load_now) begin
                     tx_sr    <= bus.I_reg_dout;
                     inc_pend <= 1'b1;
                  end
                  if (sclk_fall) begin
                     sdo   <= tx_src[DATA_SIZE-1];
                     tx_sr <= {tx_src[DATA_SIZE-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     if (bit_cnt == BYTE_LAST) begin
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_last) begin
                           state  <= WAIT_CSB;
                           sdo_oe <= 1'b0;
                           sdo    <= 1'b0;
                        end else begin
                           rd_pipe <= {rd_pipe[0], 1'b1};
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end

               WAIT_CSB: begin
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.O_sdo        = sdo;
   assign bus.O_sdo_oe     = sdo_oe;
   assign bus.O_reg_enable = reg_enable;
   assign bus.O_reg_wen    = reg_wen;
   assign bus.O_reg_addr   = reg_addr;
   assign bus.O_reg_din    = reg_din;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: SPI mode-0 host tasks, a register-file model and a write log.
module tb_spi_reg_ctrl;
   localparam int ADDR_SIZE = 8;
   localparam int DATA_SIZE = 8;
   localparam int HALF      = 60;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_reg_ctrl_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) bus ();

   spi_reg_ctrl #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   logic [7:0] mem [256];
   assign bus.I_reg_dout = mem[bus.O_reg_addr];

   int checks = 0;
   int errors = 0;

   logic [7:0] wr_addr_q [$];
   logic [7:0] wr_data_q [$];

   always @(negedge clk) begin
      if (bus.O_reg_wen) begin
         wr_addr_q.push_back(bus.O_reg_addr);
         wr_data_q.push_back(bus.O_reg_din);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic so, output logic oe);
      bus.I_sclk = 1'b0;
      bus.I_sdi  = b;
      #HALF;
      so = bus.O_sdo;
      oe = bus.O_sdo_oe;
      bus.I_sclk = 1'b1;
      #HALF;
   endtask

   task automatic spi_word(input logic [15:0] w);
      logic so, oe;
      for (int i = 15; i >= 0; i--) spi_bit(w[i], so, oe);
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] rd, output logic oe_all);
      logic oe;
      oe_all = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(b[i], rd[i], oe);
         oe_all &= oe;
      end
   endtask

   task automatic spi_begin();
      bus.I_csb = 1'b0;
      #HALF;
   endtask

   task automatic spi_end();
      bus.I_sclk = 1'b0;
      #HALF;
      bus.I_csb = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   initial begin
      logic [7:0] rd;
      logic       oe_all;
      logic       so, oe;
      int         n_exp;

      bus.I_csb  = 1'b1;
      bus.I_sclk = 1'b0;
      bus.I_sdi  = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h01] = 8'h01;
      mem[8'h10] = 8'hA5;
      mem[8'h11] = 8'h3C;
      mem[8'h20] = 8'h96;
      mem[8'h21] = 8'h69;

      repeat (3) @(posedge clk);
      #1;
      check("rst_enable", bus.O_reg_enable, 1'b0);
      check("rst_wen",    bus.O_reg_wen,    1'b0);
      check("rst_addr",   bus.O_reg_addr,   8'h00);
      check("rst_din",    bus.O_reg_din,    8'h00);
      check("rst_sdo",    {bus.O_sdo, bus.O_sdo_oe}, 2'b00);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Single-byte write
      clear_log();
      spi_begin();
      spi_word(16'h0003);
      spi_byte(8'h5A, rd, oe_all);
      check("wr1_enable_held", bus.O_reg_enable, 1'b1);
      spi_end();
      check("wr1_count", wr_addr_q.size(), 1);
      if (wr_addr_q.size() == 1) begin
         check("wr1_addr", wr_addr_q[0], 8'h03);
         check("wr1_data", wr_data_q[0], 8'h5A);
      end
      check("wr1_enable_fall", bus.O_reg_enable, 1'b0);

      // Single-byte read
      clear_log();
      spi_begin();
      spi_word(16'h8001);
      spi_byte(8'h00, rd, oe_all);
      check("rd1_data", rd, 8'h01);
      check("rd1_oe_during", oe_all, 1'b1);
      check("rd1_oe_after", bus.O_sdo_oe, 1'b0);
      check("rd1_enable_wait", bus.O_reg_enable, 1'b1);
      spi_end();
      check("rd1_enable_fall", bus.O_reg_enable, 1'b0);
      check("rd1_no_wen", wr_addr_q.size(), 0);

      // Two-byte read with auto-increment
      spi_begin();
      spi_word(16'hA010);
      spi_byte(8'h00, rd, oe_all);
      check("rd2_byte0", rd, 8'hA5);
      spi_byte(8'h00, rd, oe_all);
      check("rd2_byte1", rd, 8'h3C);
      check("rd2_oe", oe_all, 1'b1);
      spi_end();

      // Three-byte write wrapping the address
      clear_log();
      spi_begin();
      spi_word(16'h40FE);
      spi_byte(8'h11, rd, oe_all);
      spi_byte(8'h22, rd, oe_all);
      spi_byte(8'h33, rd, oe_all);
      spi_end();
      check("wrap_count", wr_addr_q.size(), 3);
      if (wr_addr_q.size() == 3) begin
         check("wrap_addr0", wr_addr_q[0], 8'hFE);
         check("wrap_data0", wr_data_q[0], 8'h11);
         check("wrap_addr1", wr_addr_q[1], 8'hFF);
         check("wrap_data1", wr_data_q[1], 8'h22);
         check("wrap_addr2", wr_addr_q[2], 8'h00);
         check("wrap_data2", wr_data_q[2], 8'h33);
      end

      // Partial byte abort, then a clean write
      clear_log();
      spi_begin();
      spi_word(16'h0020);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, so, oe);
      spi_end();
      check("abort_no_wen", wr_addr_q.size(), 0);
      check("abort_enable", bus.O_reg_enable, 1'b0);
      spi_begin();
      spi_word(16'h0007);
      spi_byte(8'hC3, rd, oe_all);
      spi_end();
      check("abort_next_count", wr_addr_q.size(), 1);
      if (wr_addr_q.size() == 1) begin
         check("abort_next_addr", wr_addr_q[0], 8'h07);
         check("abort_next_data", wr_data_q[0], 8'hC3);
      end

      // W=11 write with six bytes on the wire
      clear_log();
`ifdef SPI_STREAM_EN
      n_exp = 6;
`else
      n_exp = 4;
`endif
      spi_begin();
      spi_word(16'h6040);
      for (int i = 0; i < 6; i++) spi_byte(8'hA0 + 8'(i), rd, oe_all);
      spi_end();
      check("w11_count", wr_addr_q.size(), n_exp);
      if (wr_addr_q.size() == n_exp) begin
         for (int i = 0; i < n_exp; i++) begin
            check($sformatf("w11_addr%0d", i), wr_addr_q[i], 8'h40 + 8'(i));
            check($sformatf("w11_data%0d", i), wr_data_q[i], 8'hA0 + 8'(i));
         end
      end

      // Reset during byte 2 of a read
      clear_log();
      spi_begin();
      spi_word(16'hA020);
      spi_byte(8'h00, rd, oe_all);
      check("rstmid_byte0", rd, 8'h96);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, so, oe);
      rst_n = 1'b0;
      #1;
      check("rstmid_enable", bus.O_reg_enable, 1'b0);
      check("rstmid_oe_sdo", {bus.O_sdo_oe, bus.O_sdo}, 2'b00);
      check("rstmid_addr", bus.O_reg_addr, 8'h00);
      check("rstmid_din", bus.O_reg_din, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      spi_word(16'h0055);
      spi_byte(8'hEE, rd, oe_all);
      check("rstmid_ignored_enable", bus.O_reg_enable, 1'b0);
      check("rstmid_ignored_wen", wr_addr_q.size(), 0);
      spi_end();
      spi_begin();
      spi_word(16'h8020);
      spi_byte(8'h00, rd, oe_all);
      check("rstmid_reread", rd, 8'h96);
      spi_end();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 8: register-bus address width.
REQ-002 Parameter DATA_SIZE, default 8: register-bus data width; SPI byte width.
REQ-003 I_clk  in  1  master clock; at least 4x SCLK.
REQ-004 I_rst_n  in  1  asynchronous, active-low reset.
REQ-005 I_csb  in  1  SPI chip select, active low, asynchronous to I_clk.
REQ-006 I_sclk  in  1  SPI serial clock, asynchronous to I_clk.
REQ-007 I_sdi  in  1  SPI serial data in; sampled on SCLK rising edge.
REQ-008 O_sdo  out  1  SPI serial data out; changes on SCLK falling edge.
REQ-009 O_sdo_oe  out  1  SDO output enable; high only in read data phase.
REQ-010 O_reg_enable  out  1  register-bus access enable.
REQ-011 O_reg_wen  out  1  register write strobe; one I_clk wide.
REQ-012 O_reg_addr  out  ADDR_SIZE  register address.
REQ-013 O_reg_din  out  DATA_SIZE  register write data.
REQ-014 I_reg_dout  in  DATA_SIZE  register read data; combinational from O_reg_addr.

Function
REQ-015 I_csb, I_sclk and I_sdi SHALL each pass a 2-flop synchronizer; SCLK edges SHALL be detected from synchronized samples.
REQ-016 FSM states SHALL be IDLE, INSTR, WR_DATA, RD_DATA and WAIT_CSB.
REQ-017 IDLE -> INSTR on synchronized CSB falling edge; bit counter cleared.
REQ-018 INSTR SHALL shift 16 bits MSB-first: bit15 R/nW, bits14:13 W (00=1, 01=2, 10=3, 11=4 bytes or stream), bits12:0 address.
REQ-019 On the 16th rising edge: O_reg_addr <= address[ADDR_SIZE-1:0]; O_reg_enable <= 1; next state RD_DATA if R/nW=1, else WR_DATA.
REQ-020 WR_DATA: after each 8th data bit, O_reg_din SHALL hold the byte and O_reg_wen SHALL pulse for exactly one I_clk cycle; O_reg_addr SHALL increment on the following cycle.
REQ-021 RD_DATA: 2 I_clk cycles after the rising edge that completes the instruction or the previous data byte, I_reg_dout SHALL be loaded into the output shift register; O_reg_addr SHALL then increment.
REQ-022 RD_DATA: each SCLK falling edge SHALL drive the next bit to O_sdo, MSB first; O_sdo_oe=1 throughout RD_DATA.
REQ-023 When the byte count given by W is reached, the FSM SHALL go to WAIT_CSB; further SCLK edges SHALL be ignored.
REQ-024 O_reg_addr SHALL wrap from 2^ADDR_SIZE-1 to 0.
REQ-025 Synchronized CSB high in any non-IDLE state SHALL return the FSM to IDLE within 1 cycle. A partial byte SHALL be discarded with no write. O_reg_enable, O_sdo_oe and O_sdo SHALL clear.
REQ-026 O_reg_enable SHALL fall only on return to IDLE; its falling edge marks the end of the transaction for downstream capture.
REQ-027 A CSB falling edge detected in the same cycle as the return to IDLE SHALL be taken on the next cycle; no transaction SHALL be lost.

Reset
REQ-028 I_rst_n low SHALL immediately force the following: state=IDLE, all outputs 0, counters, shift registers and synchronizers cleared.
REQ-029 Reset asserted mid-transaction SHALL abort it; after release, the block SHALL wait for a fresh CSB falling edge.

Configuration
REQ-030 Macro SPI_STREAM_EN defined: W=11 SHALL mean streaming. Bytes SHALL continue, with address incrementing, until CSB rises, and WAIT_CSB SHALL never be entered from a data state.
REQ-031 SPI_STREAM_EN undefined: W=11 SHALL mean exactly 4 bytes, then WAIT_CSB.

Verification
REQ-032 Write 0x0003, W=00, data 0x5A -> one O_reg_wen pulse with addr 0x03, din 0x5A; enable falls after CSB high.
REQ-033 Read 0x8001, W=00, with I_reg_dout=0x01 at addr 0x01 -> O_sdo shifts 0x01 MSB first; O_sdo_oe high for 8 SCLKs only.
REQ-034 Write 0x40FE, W=10, data 11 22 33 -> writes to 0xFE, 0xFF, 0x00 (wrap), one wen each.
REQ-035 Write instruction, CSB raised after 5 data bits -> no wen; FSM back in IDLE; next transaction correct.
REQ-036 W=11 write, 6 bytes -> 6 writes with SPI_STREAM_EN defined; 4 writes without it.
REQ-037 I_rst_n pulsed low during byte 2 of a read -> all outputs 0 at once; the following read returns correct data.
